mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit; consumes the MD operation code the E-stage decoder produces for mult/multu/div/divu/mthi/mtlo.
- Owns the HI/LO architectural registers; provides HI/LO values for mfhi/mflo.
- Exports Busy so the hazard unit stalls any MD instruction (including mfhi/mflo) in D while Start or Busy is high.

Parameters:
MULT_CYCLES, 5, Busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, Busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
Start  input  1  one-cycle launch strobe from E stage, qualifies MDOp
MDOp  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved
A  input  32  rs operand (forwarded)
B  input  32  rt operand (forwarded)
Busy  output  1  registered, high while an operation is in flight
HI  output  32  HI register value
LO  output  32  LO register value

Behaviour:
- Reset is synchronous and active-high; clock is clk, reset is reset.
- Reset, including mid-operation: Busy=0, HI=0, LO=0, cycle counter=0, pending results discarded.
- Two states, IDLE and RUN.
- IDLE, Start=1, MDOp in 001..100:
  - Compute the 64-bit result from A and B at that edge into internal temp registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; Busy=1 from the next cycle.
  - HI/LO keep their old values during RUN.
- RUN: counter decrements each cycle. On the edge where counter==1:
  - commit temp to HI/LO;
  - Busy->0;
  - return to IDLE.
- Timing: Start at cycle t -> Busy high for cycles t+1..t+N -> new HI/LO visible and Busy=0 at t+N+1.
- IDLE, Start=1, MDOp=101: HI<=A at that edge. MDOp=110: LO<=A at that edge. No Busy.
- Start=1 with MDOp 000 or 111: no effect.
- Start while Busy (hazard-unit violation): ignored, with no effect on the in-flight operation.
- mult: signed 32x32 -> 64; HI = upper 32 bits, LO = lower 32 bits. multu: unsigned.
- div: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign. divu: unsigned.
- Divide by zero (B==0): run the full DIV_CYCLES with Busy high, then leave HI/LO unchanged.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Outputs are registered only. No combinational path from inputs to Busy/HI/LO.

Test Plan:
- Reset pulse mid-div (3 cycles after Start, A=100, B=7) -> next cycle Busy=0, HI=0, LO=0; no later commit.
- mult A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy high 5 cycles, then HI=0, LO=1. multu, same operands -> HI=0xFFFFFFFE, LO=0x00000001.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy high exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu, same operands -> LO=0x7FFFFFFC, HI=1.
- HI=0x11, LO=0x22 preset via mthi/mtlo, then div with B=0 -> Busy high 10 cycles, HI=0x11, LO=0x22 after. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0xDEADBEEF, next cycle mtlo A=0x12345678 -> HI/LO update at each launch edge, Busy never asserted.
- mult launched, then Start+mtlo A=0x5 during Busy -> mtlo ignored; LO equals the product's low word after commit. Back-to-back: mult Start on the cycle Busy falls (IDLE) -> accepted, Busy high again.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit owning the HI/LO registers
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [63:0] tmp, res;
  logic dz, launch, is_div, ovf, done;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] dv, q_s, r_s, q_u, r_u;
  always_comb begin
    is_div = MDOp == 3'd3 || MDOp == 3'd4;
    launch = state == IDLE && Start && MDOp >= 3'd1 && MDOp <= 3'd4;
    done = state == RUN && cnt == 4'd1;
    state_n = launch ? RUN : done ? IDLE : state;
    prod_s = $signed(A) * $signed(B);
    prod_u = {32'b0, A} * {32'b0, B};
    // substitute divisor keeps the divider defined on B==0; that result is never committed
    dv = B == 32'b0 ? 32'd1 : B;
    ovf = A == 32'h8000_0000 && B == 32'hffff_ffff;
    q_s = ovf ? A : 32'($signed(A) / $signed(dv));
    r_s = ovf ? 32'b0 : 32'($signed(A) % $signed(dv));
    q_u = A / dv;
    r_u = A % dv;
    res = MDOp == 3'd1 ? prod_s : MDOp == 3'd2 ? prod_u : MDOp == 3'd3 ? {r_s, q_s} : {r_u, q_u};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      Busy <= 1'b0;
      HI <= '0;
      LO <= '0;
      cnt <= '0;
      tmp <= '0;
      dz <= 1'b0;
    end else begin
      state <= state_n;
      Busy <= state_n == RUN;
      if (launch) begin
        tmp <= res;
        cnt <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        dz <= is_div && B == 32'b0;
      end else if (state == RUN) cnt <= cnt - 4'd1;
      if (state == IDLE && Start && MDOp == 3'd5) HI <= A;
      if (state == IDLE && Start && MDOp == 3'd6) LO <= A;
      if (done && !dz) {HI, LO} <= tmp;
    end
  end
endmodule
